// File: rtl/memory_write_control_pkg.sv
// Shared types and constants for the frame-memory write stage.
// Covers the pixel packing lanes and the write FSM.
package memory_write_control_pkg;

  localparam int PIX_PER_WORD = 4;
  localparam int LANE_WIDTH   = $clog2(PIX_PER_WORD);

  typedef logic [LANE_WIDTH-1:0] lane_t;

  localparam lane_t LAST_LANE = lane_t'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {
    S_WIDLE   = 2'd0,
    S_WACTIVE = 2'd1,
    S_WDONE   = 2'd2
  } wstate_t;

endpackage

// File: rtl/memory_write_control_if.sv
// Pixel stream in, memory write bus and sticky error flags out.
// The slave modport is the write controller; the master modport is the pixel source.
interface memory_write_control_if #(
  parameter int PIX_WIDTH  = 24,
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 16
);

  logic                  i_vsync;
  logic                  i_de;
  logic [PIX_WIDTH-1:0]  i_pixel;
  logic                  i_err_clr;
  logic                  o_wen;
  logic [ADDR_WIDTH-1:0] o_waddr;
  logic [DATA_WIDTH-1:0] o_wdata;
  logic                  o_frame_done;
  logic                  o_err_partial;
  logic                  o_err_ovf;

  modport master (
    output i_vsync, i_de, i_pixel, i_err_clr,
    input  o_wen, o_waddr, o_wdata, o_frame_done, o_err_partial, o_err_ovf
  );

  modport slave (
    input  i_vsync, i_de, i_pixel, i_err_clr,
    output o_wen, o_waddr, o_wdata, o_frame_done, o_err_partial, o_err_ovf
  );

endinterface

// File: rtl/memory_write_control_pixel_packer.sv
// Packs four pixels into one memory word and strobes when a word is complete
// or when a partial word must be flushed at the end of a line.
module memory_write_control_pixel_packer
  import memory_write_control_pkg::*;
#(
  parameter int PIX_WIDTH  = 24,
  parameter int DATA_WIDTH = PIX_WIDTH * PIX_PER_WORD
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_pack_en,
  input  logic                  i_de,
  input  logic [PIX_WIDTH-1:0]  i_pixel,
  output logic                  o_pending,
  output logic                  o_full,
  output logic                  o_flush,
  output logic [DATA_WIDTH-1:0] o_word
);

  lane_t                lane_q;
  logic [PIX_WIDTH-1:0] hold_q [PIX_PER_WORD-1];
  logic                 accept;

  assign accept    = i_pack_en & i_de;
  assign o_pending = (lane_q != '0);
  assign o_full    = accept & (lane_q == LAST_LANE);
  assign o_flush   = i_pack_en & ~i_de & o_pending;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else if (i_clear || o_flush) begin
      lane_q <= '0;
    end else if (accept) begin
      lane_q <= lane_q + lane_t'(1);
    end
  end

  // NOTE: holding lanes are pure datapath; lanes above lane_q are masked out
  // of o_word, so stale contents are harmless and the array needs no reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < PIX_PER_WORD - 1; i++) begin
      if (accept && (lane_q == lane_t'(i))) hold_q[i] <= i_pixel;
    end
  end

  // The last lane comes straight from the input so the word is written on the 4th pixel's edge.
  always_comb begin
    o_word = '0;
    for (int i = 0; i < PIX_PER_WORD - 1; i++) begin
      if (i < int'(lane_q)) o_word[i*PIX_WIDTH +: PIX_WIDTH] = hold_q[i];
    end
    if (o_full) o_word[(PIX_PER_WORD-1)*PIX_WIDTH +: PIX_WIDTH] = i_pixel;
  end

endmodule

// File: rtl/memory_write_control.sv
// Frame-buffer write stage: vsync realignment, write FSM, address counter
// and sticky error flags around the pixel packer.
module memory_write_control
  import memory_write_control_pkg::*;
#(
  parameter int DATA_WIDTH = 96,
  parameter int PIX_WIDTH  = 24,
  parameter int ADDR_DEPTH = 512 * 512 / 4,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
  input logic                    i_clk,
  input logic                    rst_n,
  memory_write_control_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);

  wstate_t               state_q, state_d;
  logic                  vs_d;
  logic                  vs_rise;
  logic                  pack_en;
  logic                  pending;
  logic                  full;
  logic                  flush;
  logic                  wr;
  logic                  last_wr;
  logic                  ovf_set;
  logic                  partial_set;
  logic [ADDR_WIDTH-1:0] word_cnt_q;
  logic [DATA_WIDTH-1:0] word;

  // vsync outranks pixel traffic: a rising edge blocks packing in that cycle.
  assign vs_rise     = bus.i_vsync & ~vs_d;
  assign pack_en     = (state_q == S_WACTIVE) & ~vs_rise;
  assign wr          = full | flush;
  assign last_wr     = wr & (word_cnt_q == LAST_ADDR);
  assign ovf_set     = (state_q == S_WDONE) & bus.i_de & ~vs_rise;
  assign partial_set = flush | (vs_rise & pending);

  memory_write_control_pixel_packer #(
    .PIX_WIDTH  (PIX_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .i_clk     (i_clk),
    .rst_n     (rst_n),
    .i_clear   (vs_rise),
    .i_pack_en (pack_en),
    .i_de      (bus.i_de),
    .i_pixel   (bus.i_pixel),
    .o_pending (pending),
    .o_full    (full),
    .o_flush   (flush),
    .o_word    (word)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WIDLE;
      vs_d    <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_d    <= bus.i_vsync;
    end
  end

  // NOTE: state_d is defaulted first so no branch leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WIDLE:   if (vs_rise) state_d = S_WACTIVE;
      S_WACTIVE: if (last_wr) state_d = S_WDONE;
      S_WDONE:   if (vs_rise) state_d = S_WACTIVE;
      default:   state_d = S_WIDLE;
    endcase
  end

  // The count saturates on the last word; S_WDONE then holds it until vsync.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q       <= '0;
      bus.o_wen        <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_waddr      <= '0;
      bus.o_wdata      <= '0;
    end else begin
      bus.o_wen        <= wr;
      bus.o_frame_done <= last_wr;
      if (wr) begin
        bus.o_waddr <= word_cnt_q;
        bus.o_wdata <= word;
      end
      if (vs_rise) begin
        word_cnt_q <= '0;
      end else if (wr && !last_wr) begin
        word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_err_partial <= 1'b0;
      bus.o_err_ovf     <= 1'b0;
    end else begin
      if (partial_set)        bus.o_err_partial <= 1'b1;
      else if (bus.i_err_clr) bus.o_err_partial <= 1'b0;
      if (ovf_set)            bus.o_err_ovf     <= 1'b1;
      else if (bus.i_err_clr) bus.o_err_ovf     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_write_control.sv
// Directed bench for memory_write_control with an 8-word frame:
// full frame, pre-vsync pixels, flush, overflow, vsync discard and mid-frame reset.
module tb_memory_write_control;
  import memory_write_control_pkg::*;

  localparam int PW    = 24;
  localparam int DW    = 96;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic i_clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 i_clk = ~i_clk;

  memory_write_control_if #(.PIX_WIDTH(PW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  memory_write_control #(
    .DATA_WIDTH (DW),
    .PIX_WIDTH  (PW),
    .ADDR_DEPTH (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk (i_clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  logic          log_done [$];

  // Each write pulse lasts exactly one cycle, so one negedge sees it once.
  always @(negedge i_clk) begin
    if (bus.o_wen === 1'b1) begin
      log_addr.push_back(bus.o_waddr);
      log_data.push_back(bus.o_wdata);
      log_done.push_back(bus.o_frame_done);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [PW-1:0] p0, p1, p2, p3;
    p0 = PW'(a);
    p1 = PW'(b);
    p2 = PW'(c);
    p3 = PW'(d);
    return {p3, p2, p1, p0};
  endfunction

  task automatic cycle(input logic vs, input logic de, input int pix, input logic clr = 1'b0);
    bus.i_vsync   = vs;
    bus.i_de      = de;
    bus.i_pixel   = PW'(pix);
    bus.i_err_clr = clr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic vsync_pulse();
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_done.delete();
  endtask

  initial begin
    bus.i_vsync   = 1'b0;
    bus.i_de      = 1'b0;
    bus.i_pixel   = '0;
    bus.i_err_clr = 1'b0;

    // Reset values
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_wen",     bus.o_wen,         0);
    check("rst_waddr",   bus.o_waddr,       0);
    check("rst_wdata",   bus.o_wdata,       0);
    check("rst_done",    bus.o_frame_done,  0);
    check("rst_partial", bus.o_err_partial, 0);
    check("rst_ovf",     bus.o_err_ovf,     0);
    check("rst_state",   dut.state_q,       S_WIDLE);
    @(negedge i_clk);
    rst_n = 1'b1;

    // Pixels before the first vsync are ignored
    for (int i = 50; i < 54; i++) cycle(1'b0, 1'b1, i);
    cycle(1'b0, 1'b0, 0);
    check("idle_nwrites", log_addr.size(), 0);
    check("idle_partial", bus.o_err_partial, 0);
    check("idle_ovf",     bus.o_err_ovf,     0);
    check("idle_state",   dut.state_q,       S_WIDLE);

    // Full frame of 32 pixels -> 8 words
    vsync_pulse();
    for (int i = 1; i <= 32; i++) begin
      cycle(1'b0, 1'b1, i);
      if (i == 3) check("frame_wen_early", bus.o_wen, 0);
      if (i == 4) begin
        check("frame_w0_wen",   bus.o_wen,    1);
        check("frame_w0_addr",  bus.o_waddr,  0);
        check("frame_w0_data",  bus.o_wdata,  pack4(1, 2, 3, 4));
        check("frame_w0_done",  bus.o_frame_done, 0);
      end
      if (i == 32) begin
        check("frame_w7_wen",  bus.o_wen,         1);
        check("frame_w7_addr", bus.o_waddr,       7);
        check("frame_w7_done", bus.o_frame_done,  1);
      end
    end
    cycle(1'b0, 1'b0, 0);
    check("frame_wen_drop",  bus.o_wen,         0);
    check("frame_done_drop", bus.o_frame_done,  0);
    check("frame_addr_hold", bus.o_waddr,       7);
    check("frame_data_hold", bus.o_wdata,       pack4(29, 30, 31, 32));
    check("frame_state",     dut.state_q,       S_WDONE);
    check("frame_nwrites",   log_addr.size(),   8);
    for (int k = 0; k < 8; k++) begin
      if (k < log_addr.size()) begin
        check($sformatf("frame_log%0d_addr", k), log_addr[k], k);
        check($sformatf("frame_log%0d_data", k), log_data[k],
              pack4(4*k + 1, 4*k + 2, 4*k + 3, 4*k + 4));
        check($sformatf("frame_log%0d_done", k), log_done[k], (k == 7));
      end
    end
    check("frame_partial", bus.o_err_partial, 0);
    check("frame_ovf",     bus.o_err_ovf,     0);

    // Overflow after the frame is full; first pixel also carries a clear
    clear_log();
    cycle(1'b0, 1'b1, 60, 1'b1);
    check("ovf_set_wins", bus.o_err_ovf, 1);
    for (int i = 61; i < 64; i++) cycle(1'b0, 1'b1, i);
    cycle(1'b0, 1'b0, 0);
    check("ovf_nwrites", log_addr.size(),   0);
    check("ovf_flag",    bus.o_err_ovf,     1);
    check("ovf_partial", bus.o_err_partial, 0);
    vsync_pulse();
    for (int i = 100; i < 104; i++) cycle(1'b0, 1'b1, i);
    check("ovf_next_wen",  bus.o_wen,    1);
    check("ovf_next_addr", bus.o_waddr,  0);
    check("ovf_next_data", bus.o_wdata,  pack4(100, 101, 102, 103));
    cycle(1'b0, 1'b0, 0, 1'b1);
    check("ovf_cleared", bus.o_err_ovf, 0);

    // Short line of 6 pixels -> full word plus zero-padded flush
    clear_log();
    vsync_pulse();
    for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b1, i);
    cycle(1'b0, 1'b0, 0);
    check("flush_wen",     bus.o_wen,         1);
    check("flush_addr",    bus.o_waddr,       1);
    check("flush_data",    bus.o_wdata,       pack4(5, 6, 0, 0));
    check("flush_partial", bus.o_err_partial, 1);
    cycle(1'b0, 1'b0, 0, 1'b1);
    check("flush_nwrites",   log_addr.size(), 2);
    if (log_addr.size() >= 1) begin
      check("flush_log0_addr", log_addr[0], 0);
      check("flush_log0_data", log_data[0], pack4(1, 2, 3, 4));
    end
    check("flush_cleared", bus.o_err_partial, 0);

    // vsync with two pixels pending and de high in the same cycle
    clear_log();
    vsync_pulse();
    cycle(1'b0, 1'b1, 7);
    cycle(1'b0, 1'b1, 8);
    cycle(1'b1, 1'b1, 9, 1'b1);
    check("vsdrop_partial", bus.o_err_partial, 1);
    check("vsdrop_wen",     bus.o_wen,         0);
    for (int i = 11; i < 15; i++) cycle(1'b0, 1'b1, i);
    check("vsdrop_wen2",  bus.o_wen,   1);
    check("vsdrop_addr",  bus.o_waddr, 0);
    check("vsdrop_data",  bus.o_wdata, pack4(11, 12, 13, 14));
    cycle(1'b0, 1'b0, 0);
    check("vsdrop_nwrites", log_addr.size(), 1);

    // Asynchronous reset mid-frame with two lanes filled
    vsync_pulse();
    cycle(1'b0, 1'b1, 21);
    cycle(1'b0, 1'b1, 22);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_wen",     bus.o_wen,           0);
    check("mrst_waddr",   bus.o_waddr,         0);
    check("mrst_wdata",   bus.o_wdata,         0);
    check("mrst_done",    bus.o_frame_done,    0);
    check("mrst_partial", bus.o_err_partial,   0);
    check("mrst_ovf",     bus.o_err_ovf,       0);
    check("mrst_state",   dut.state_q,         S_WIDLE);
    check("mrst_lanes",   dut.u_packer.lane_q, 0);
    @(negedge i_clk);
    rst_n = 1'b1;
    clear_log();
    vsync_pulse();
    for (int i = 31; i < 35; i++) cycle(1'b0, 1'b1, i);
    check("mrst_next_wen",  bus.o_wen,    1);
    check("mrst_next_addr", bus.o_waddr,  0);
    check("mrst_next_data", bus.o_wdata,  pack4(31, 32, 33, 34));
    cycle(1'b0, 1'b0, 0);
    check("mrst_nwrites", log_addr.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_write_control.md
Name: memory_write_control

Overview:
- Upstream write stage of the frame memory controller. Feeds the frame buffer that the read controller scans out.
- Accepts a raster pixel stream (vsync, data-enable, 24-bit pixels) and packs 4 pixels into each 96-bit word.
- Issues one write per word at sequential addresses from 0, realigning to address 0 on every vsync.
- Flags partial words and frame overflow with sticky error bits.

Parameters:
- DATA_WIDTH, 96, memory word width; must be PIX_WIDTH × 4.
- PIX_WIDTH, 24, pixel width (RGB888).
- ADDR_DEPTH, 512*512/4, words per frame.
- ADDR_WIDTH, $clog2(ADDR_DEPTH), write address width.

Ports:
- i_clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_vsync  input  1  frame sync, active high; its rising edge marks frame start.
- i_de  input  1  pixel valid / active video.
- i_pixel  input  PIX_WIDTH  pixel data, sampled when i_de=1.
- i_err_clr  input  1  clears sticky error flags.
- o_wen  output  1  memory write enable, one-cycle pulse per word.
- o_waddr  output  ADDR_WIDTH  write address.
- o_wdata  output  DATA_WIDTH  packed word; pixel 0 in bits [23:0], pixel 3 in bits [95:72].
- o_frame_done  output  1  one-cycle pulse coincident with the last word write of a frame.
- o_err_partial  output  1  sticky; a partial word was flushed or discarded.
- o_err_ovf  output  1  sticky; pixels arrived after the frame was full.

Behaviour:
- Reset, asynchronous: all outputs 0, state S_WIDLE, lane count 0, word count 0, vsync delay register 0.
- vs_rise = i_vsync & ~vs_d, where vs_d is i_vsync registered.
- States:
  - S_WIDLE: i_de ignored, no writes. vs_rise → S_WACTIVE.
  - S_WACTIVE: packs pixels and writes words. Writing word ADDR_DEPTH-1 → S_WDONE. vs_rise → stays in S_WACTIVE and restarts.
  - S_WDONE: no writes. i_de=1 sets o_err_ovf and the pixel is dropped. vs_rise → S_WACTIVE.
- Actions on vs_rise (any state):
  - Word count ← 0 and lane count ← 0.
  - If lane count > 0, the partial word is discarded and o_err_partial is set.
  - i_de in the same cycle is ignored; vsync has priority.
- Short frame (vs_rise before ADDR_DEPTH words): no error; writing simply restarts at address 0.
- Packing in S_WACTIVE with i_de=1:
  - The pixel is stored in lane = lane count, and lane count increments modulo 4.
  - On lane 3, at that same edge: o_wen←1, o_wdata←{pixel, lanes2..0}, o_waddr←word count, word count increments.
  - Latency: o_wen is high in the cycle immediately after the 4th pixel is presented.
  - Back-to-back: one write every 4 cycles at full pixel rate.
- Flush in S_WACTIVE with i_de=0 and lane count > 0 (line ended mid-word):
  - Next edge writes the stored lanes with unused upper lanes zero-padded.
  - Lane count ← 0, word count increments, o_err_partial set.
- Frame done: when the write uses address ADDR_DEPTH-1 (normal or flush), o_frame_done←1 in the same cycle as o_wen, and the state moves to S_WDONE.
- o_wen and o_frame_done deassert the cycle after any pulse.
- o_waddr and o_wdata hold their last values when o_wen=0.
- Word count width is ADDR_WIDTH and never wraps inside a frame; S_WDONE blocks any further increment.
- i_err_clr clears both sticky flags at the next edge. A set condition in the same cycle wins over the clear.
- Reset mid-frame: immediate return to reset values; a write in flight is lost.

Decomposition:
- state_pkg gains typedef enum Wstate_t {S_WIDLE, S_WACTIVE, S_WDONE} and localparam PIX_PER_WORD = 4.
- One natural sub-module: pixel_packer, holding the lane counter, 3-lane holding registers, word assembly with zero pad, and the full/flush strobe.
- The top level holds the FSM, vsync edge detect, address counter and error flags.

Test Plan:
- ADDR_DEPTH=8. After reset, vsync pulse, then 32 pixels with de=1, values 1..32 → 8 writes at addr 0..7; word0 = {4,3,2,1}; o_frame_done together with the addr 7 write; no errors.
- Pixels presented before the first vsync → no o_wen, no error flags, state stays S_WIDLE.
- After vsync, 6 pixels (values 1..6), then de low → writes {4,3,2,1}@0 and {0,0,6,5}@1 one cycle after de falls; o_err_partial=1.
- Full frame completed, then 4 more pixels → no writes, o_err_ovf=1. Next vsync, then 4 pixels → write at addr 0.
- Vsync rises while 2 pixels are pending and de=1 in the same cycle → pending pixels discarded, o_err_partial=1; next 4 pixels are written to addr 0.
- Assert rst_n=0 mid-frame with 2 lanes filled → all outputs 0 immediately. After release, vsync plus 4 pixels → write at addr 0. A set condition asserted together with i_err_clr → the flag stays 1.
